// File: rtl/mem_wb.sv
// Memory / write-back stage: issues one data-bus transaction per load or store
// and writes ALU or load results to the register file. Optional MEM_TIMEOUT_EN adds a bus-wait timeout.
module mem_wb #(
  parameter int XLEN       = 32,
  parameter int TMO_CYCLES = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic            ex_mem_re,
  input  logic            ex_mem_we,
  input  logic [XLEN-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_wdata,
  input  logic [XLEN-1:0] ex_result,
  input  logic [3:0]      ex_rd,
  input  logic            ex_rd_we,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            rf_we,
  output logic [3:0]      rf_addr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            bus_err
);

  // Handshake: ex_* is captured on the rising edge where ex_valid && ex_ready.
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WB} state_t;

  state_t          state, state_nxt;
  logic [3:0]      rd_q;
  logic            rd_ok_q;
  logic            accept, ex_is_mem, ex_rd_ok, tmo_hit;
  logic            ex_ready_d, dmem_req_d, dmem_we_d, rf_we_d;
  logic [XLEN-1:0] dmem_addr_d, dmem_wdata_d, rf_wdata_d;
  logic [3:0]      rf_addr_d;

  assign accept    = (state == S_IDLE) && ex_valid;
  assign ex_is_mem = ex_mem_re || ex_mem_we;
  assign ex_rd_ok  = ex_rd_we && (ex_rd != 4'd0);

`ifdef MEM_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       progress;

  assign progress = ((state == S_REQ) && dmem_gnt) || ((state == S_WAIT) && dmem_rvalid);
  assign tmo_hit  = ((state == S_REQ) || (state == S_WAIT)) && !progress
                    && (tmo_cnt == 8'(TMO_CYCLES - 1));

  // Counts the combined REQ+WAIT residency of the current transaction.
  always_ff @(posedge clk) begin
    if (reset || state == S_IDLE) tmo_cnt <= 8'd0;
    else if (state == S_REQ || state == S_WAIT) tmo_cnt <= tmo_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset)        bus_err <= 1'b0;
    else if (tmo_hit) bus_err <= 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      ex_ready   <= 1'b1;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      rf_we      <= 1'b0;
      rf_addr    <= 4'd0;
      rf_wdata   <= '0;
      rd_q       <= 4'd0;
      rd_ok_q    <= 1'b0;
    end else begin
      state      <= state_nxt;
      ex_ready   <= ex_ready_d;
      dmem_req   <= dmem_req_d;
      dmem_we    <= dmem_we_d;
      dmem_addr  <= dmem_addr_d;
      dmem_wdata <= dmem_wdata_d;
      rf_we      <= rf_we_d;
      rf_addr    <= rf_addr_d;
      rf_wdata   <= rf_wdata_d;
      if (accept) begin
        rd_q    <= ex_rd;
        rd_ok_q <= ex_rd_ok;
      end
    end
  end

  // While in REQ, the registered dmem_we tells a store (done on grant) from a load.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (ex_valid) state_nxt = ex_is_mem ? S_REQ : S_WB;
      S_REQ: begin
        if (dmem_gnt)     state_nxt = dmem_we ? S_IDLE : S_WAIT;
        else if (tmo_hit) state_nxt = S_IDLE;
      end
      S_WAIT: begin
        if (dmem_rvalid)  state_nxt = S_WB;
        else if (tmo_hit) state_nxt = S_IDLE;
      end
      S_WB:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the next state.
  always_comb begin
    ex_ready_d   = (state_nxt == S_IDLE);
    dmem_req_d   = (state_nxt == S_REQ);
    dmem_we_d    = 1'b0;
    dmem_addr_d  = dmem_addr;
    dmem_wdata_d = dmem_wdata;
    rf_we_d      = 1'b0;
    rf_addr_d    = rf_addr;
    rf_wdata_d   = rf_wdata;
    if (state_nxt == S_REQ) dmem_we_d = accept ? ex_mem_we : dmem_we;
    if (accept && ex_is_mem) begin
      dmem_addr_d  = ex_addr;
      dmem_wdata_d = ex_wdata;
    end
    if (state_nxt == S_WB) begin
      if (accept) begin
        rf_we_d    = ex_rd_ok;
        rf_addr_d  = ex_rd;
        rf_wdata_d = ex_result;
      end else begin
        rf_we_d    = rd_ok_q;
        rf_addr_d  = rd_q;
        rf_wdata_d = dmem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb.sv
// Directed and randomized bench for mem_wb; register-file writes are checked against
// a scoreboard of expected {rd, data} pairs. Define MEM_TIMEOUT_EN to also exercise the timeout.
module tb_mem_wb;
  localparam int XLEN = 32;
  localparam int W    = XLEN + 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            ex_valid, ex_ready, ex_mem_re, ex_mem_we, ex_rd_we;
  logic [XLEN-1:0] ex_addr, ex_wdata, ex_result;
  logic [3:0]      ex_rd;
  logic            dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [XLEN-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic            rf_we, bus_err;
  logic [3:0]      rf_addr;
  logic [XLEN-1:0] rf_wdata;

  logic [W-1:0] exp_q[$];
  int n_pass = 0, n_total = 0, n_pushed = 0, n_writes = 0;

  mem_wb #(.XLEN(XLEN), .TMO_CYCLES(255)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_result(ex_result),
    .ex_rd(ex_rd), .ex_rd_we(ex_rd_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .bus_err(bus_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic drive_op(input logic re, input logic we, input logic [XLEN-1:0] addr,
                          input logic [XLEN-1:0] wdata, input logic [XLEN-1:0] result,
                          input logic [3:0] rd, input logic rd_we);
    ex_valid = 1'b1; ex_mem_re = re; ex_mem_we = we; ex_addr = addr;
    ex_wdata = wdata; ex_result = result; ex_rd = rd; ex_rd_we = rd_we;
  endtask

  task automatic expect_write(input logic [3:0] rd, input logic [XLEN-1:0] data);
    exp_q.push_back({rd, data});
    n_pushed++;
  endtask

  // scoreboard: every rf_we cycle must match the oldest expected write
  always @(negedge clk) begin
    if (!reset && rf_we) begin
      logic [W-1:0] e;
      n_writes++;
      check("rf_write_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rf_addr", 64'(rf_addr), 64'(e[W-1:XLEN]));
        check("rf_wdata", 64'(rf_wdata), 64'(e[XLEN-1:0]));
      end
    end
  end

  initial begin
    logic [3:0]      rd;
    logic            rdw;
    logic [XLEN-1:0] data;
    int              gd, rvd;

    reset = 1'b1; ex_valid = 1'b0; ex_mem_re = 1'b0; ex_mem_we = 1'b0; ex_rd_we = 1'b0;
    ex_addr = '0; ex_wdata = '0; ex_result = '0; ex_rd = 4'd0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    step(); step();
    check("rst_ex_ready", 64'(ex_ready), 64'd1);
    check("rst_dmem_req", 64'(dmem_req), 64'd0);
    check("rst_dmem_we", 64'(dmem_we), 64'd0);
    check("rst_rf_we", 64'(rf_we), 64'd0);
    check("rst_bus_err", 64'(bus_err), 64'd0);
    check("rst_dmem_addr", 64'(dmem_addr), 64'd0);
    check("rst_dmem_wdata", 64'(dmem_wdata), 64'd0);
    check("rst_rf_addr", 64'(rf_addr), 64'd0);
    check("rst_rf_wdata", 64'(rf_wdata), 64'd0);
    reset = 1'b0;

    // ALU op rd=3 result 0xAA
    drive_op(1'b0, 1'b0, '0, '0, 32'h0000_00AA, 4'd3, 1'b1);
    expect_write(4'd3, 32'h0000_00AA);
    step(); ex_valid = 1'b0;
    check("alu_rf_we", 64'(rf_we), 64'd1);
    check("alu_ex_ready_busy", 64'(ex_ready), 64'd0);
    step();
    check("alu_ex_ready_back", 64'(ex_ready), 64'd1);
    check("alu_rf_we_pulse", 64'(rf_we), 64'd0);

    // stray rvalid while idle is ignored
    dmem_rvalid = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
    step(); dmem_rvalid = 1'b0;
    check("stray_rvalid_idle", 64'(ex_ready), 64'd1);

    // load addr 0x10 rd=5, grant on first REQ cycle
    drive_op(1'b1, 1'b0, 32'h10, 32'h0, 32'h0, 4'd5, 1'b1);
    expect_write(4'd5, 32'hDEAD_BEEF);
    step(); ex_valid = 1'b0;
    check("ld_req", 64'(dmem_req), 64'd1);
    check("ld_we", 64'(dmem_we), 64'd0);
    check("ld_addr", 64'(dmem_addr), 64'h10);
    dmem_gnt = 1'b1;
    step(); dmem_gnt = 1'b0;
    check("ld_req_drop", 64'(dmem_req), 64'd0);
    step();
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    step(); dmem_rvalid = 1'b0;
    check("ld_rf_we", 64'(rf_we), 64'd1);
    step();
    check("ld_ready_back", 64'(ex_ready), 64'd1);

    // store addr 0x20 data 0x1234, grant after 3 cycles
    drive_op(1'b0, 1'b1, 32'h20, 32'h1234, 32'h0, 4'd4, 1'b1);
    step(); ex_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("st_req", 64'(dmem_req), 64'd1);
      check("st_we", 64'(dmem_we), 64'd1);
      check("st_addr", 64'(dmem_addr), 64'h20);
      check("st_wdata", 64'(dmem_wdata), 64'h1234);
      dmem_gnt = (i == 3);
      step();
    end
    dmem_gnt = 1'b0;
    check("st_req_done", 64'(dmem_req), 64'd0);
    check("st_we_done", 64'(dmem_we), 64'd0);
    check("st_ready_back", 64'(ex_ready), 64'd1);

    // rd=0 and rd_we=0: WB visited, no write
    drive_op(1'b0, 1'b0, '0, '0, 32'hFF, 4'd0, 1'b1);
    step(); ex_valid = 1'b0;
    check("rd0_wb_visit", 64'(ex_ready), 64'd0);
    check("rd0_no_we", 64'(rf_we), 64'd0);
    step();
    check("rd0_ready_back", 64'(ex_ready), 64'd1);
    drive_op(1'b0, 1'b0, '0, '0, 32'h77, 4'd7, 1'b0);
    step(); ex_valid = 1'b0;
    check("rdwe0_wb_visit", 64'(ex_ready), 64'd0);
    step();

    // re and we both set: store only
    drive_op(1'b1, 1'b1, 32'h30, 32'h55, 32'h0, 4'd6, 1'b1);
    step(); ex_valid = 1'b0;
    check("rewe_req", 64'(dmem_req), 64'd1);
    check("rewe_we", 64'(dmem_we), 64'd1);
    dmem_gnt = 1'b1;
    step(); dmem_gnt = 1'b0;
    check("rewe_idle", 64'(ex_ready), 64'd1);
    check("rewe_req_drop", 64'(dmem_req), 64'd0);
    step();

    // reset during WAIT, late rvalid
    drive_op(1'b1, 1'b0, 32'h40, 32'h0, 32'h0, 4'd9, 1'b1);
    step(); ex_valid = 1'b0;
    dmem_gnt = 1'b1;
    step(); dmem_gnt = 1'b0;
    reset = 1'b1;
    step(); reset = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_0077;
    step(); dmem_rvalid = 1'b0;
    check("rstwait_ready", 64'(ex_ready), 64'd1);
    check("rstwait_rf_we", 64'(rf_we), 64'd0);
    check("rstwait_req", 64'(dmem_req), 64'd0);

    // randomized ALU ops and loads with random bus latencies
    for (int k = 0; k < 8; k++) begin
      rd = 4'($urandom_range(0, 15));
      rdw = 1'($urandom_range(0, 1));
      data = $urandom;
      if (rdw && rd != 4'd0) expect_write(rd, data);
      if ($urandom_range(0, 1) == 0) begin
        drive_op(1'b0, 1'b0, '0, '0, data, rd, rdw);
        step(); ex_valid = 1'b0;
        step();
      end else begin
        gd = $urandom_range(0, 3);
        rvd = $urandom_range(0, 3);
        drive_op(1'b1, 1'b0, 32'($urandom), '0, '0, rd, rdw);
        step(); ex_valid = 1'b0;
        for (int j = 0; j < gd; j++) begin
          check("rnd_req_hold", 64'(dmem_req), 64'd1);
          step();
        end
        dmem_gnt = 1'b1;
        step(); dmem_gnt = 1'b0;
        for (int j = 0; j < rvd; j++) begin
          check("rnd_wait_noreq", 64'(dmem_req), 64'd0);
          step();
        end
        dmem_rvalid = 1'b1; dmem_rdata = data;
        step(); dmem_rvalid = 1'b0;
        step();
      end
      check("rnd_ready_back", 64'(ex_ready), 64'd1);
    end

`ifdef MEM_TIMEOUT_EN
    // store with no grant: timeout after 255 cycles in REQ
    drive_op(1'b0, 1'b1, 32'h50, 32'h99, 32'h0, 4'd1, 1'b1);
    step(); ex_valid = 1'b0;
    repeat (254) step();
    check("tmo_still_req", 64'(dmem_req), 64'd1);
    step();
    check("tmo_idle", 64'(ex_ready), 64'd1);
    check("tmo_req_drop", 64'(dmem_req), 64'd0);
    check("tmo_bus_err", 64'(bus_err), 64'd1);
    drive_op(1'b0, 1'b0, '0, '0, 32'h0000_0042, 4'd2, 1'b1);
    expect_write(4'd2, 32'h0000_0042);
    step(); ex_valid = 1'b0;
    check("tmo_alu_we", 64'(rf_we), 64'd1);
    step();
    check("tmo_bus_err_sticky", 64'(bus_err), 64'd1);
`else
    check("bus_err_const0", 64'(bus_err), 64'd0);
`endif

    step(); step();
    check("sb_queue_empty", 64'(exp_q.size()), 64'd0);
    check("sb_write_count", 64'(n_writes), 64'(n_pushed));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
